// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   tx_state_t           - transmit FSM state encoding (also exported as a debug port)
//   UART_DATA_WIDTH      - default data bits per frame
//   DEFAULT_CLKS_PER_BIT - 100 MHz clock / 115200 baud
//   parity_calc()        - parity bit for a data word; odd=0 gives even parity
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_WIDTH      = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Even parity makes the total count of ones even, so the parity bit is
  // the XOR of the data; odd parity inverts it.
  function automatic logic parity_calc(input logic [UART_DATA_WIDTH-1:0] data,
                                       input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate counter shared by the UART transmitter and receiver.
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   clear    - synchronous restart of the count at 0 (bit phase alignment)
//   en       - count enable; the counter holds its value when low
//   bit_tick - high on the last clk of each bit period (count == CLKS_PER_BIT-1)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  assign bit_tick = en && (baud_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      baud_cnt <= '0;
    end else if (en) begin
      baud_cnt <= bit_tick ? '0 : baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains bytes straight from a sync FIFO read port and
// serialises each as start bit, LSB-first data, optional parity, stop bit(s).
//   clk, reset     - system clock, synchronous active-high reset
//   fifo_empty     - FIFO empty flag (only looked at in IDLE)
//   fifo_data      - FIFO data_out, valid the cycle after fifo_read_req
//   fifo_read_req  - single-cycle pop, only ever high in IDLE
//   parity_en      - insert a parity bit; captured in LOAD
//   parity_odd     - 1 = odd parity, 0 = even; captured in LOAD
//   tx             - serial line, idle high
//   busy           - high from LOAD through the last stop-bit cycle
//   tx_done        - one-cycle pulse on the last clk of the final stop bit
//   state          - current FSM state, exported for debug/checkers
//
// Pop handshake: fifo_read_req is a request with no ready; the FIFO returns
// the popped word one cycle later, which is exactly the LOAD cycle.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_req,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output tx_state_t             state
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  bit_tick;
  logic                  baud_en;
  logic                  last_stop;

  assign fifo_read_req = (state == IDLE) && !fifo_empty && !reset;
  assign baud_en       = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
  assign last_stop     = (STOP_BITS == 2) ? stop_idx : 1'b1;

  // Decoded from registered state and counter so it lines up with the final
  // stop-bit cycle rather than arriving one clock late.
  assign tx_done = (state == STOP) && last_stop && bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == LOAD),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  // tx is registered, so each transition loads the level of the bit that
  // the next state will drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shift_reg <= fifo_data;
          par_en_q  <= parity_en;
          par_bit   <= (^fifo_data) ^ parity_odd;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_tick) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_q) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (last_stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;
  import uart_pkg::*;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_odd;
    logic       exp_par;
    int         exp_len;
    logic       dut;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic sel = 1'b0;

  // ---------------- FIFO models (one per DUT) ----------------
  logic [7:0] mem1 [0:63];
  logic [7:0] mem2 [0:63];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  logic [7:0] fifo_data1 = '0, fifo_data2 = '0;
  logic fifo_empty1, fifo_empty2;
  assign fifo_empty1 = (wr1 == rd1);
  assign fifo_empty2 = (wr2 == rd2);

  logic rr1, rr2, tx1, tx2, busy1, busy2, done1, done2;
  tx_state_t state1, state2;

  always @(posedge clk) begin
    if (rr1) begin
      fifo_data1 <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
    if (rr2) begin
      fifo_data2 <= mem2[rd2];
      rd2 <= rd2 + 1;
    end
  end

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_read_req(rr1), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx1), .busy(busy1), .tx_done(done1), .state(state1)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_read_req(rr2), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx2), .busy(busy2), .tx_done(done2), .state(state2)
  );

  logic tx_s, busy_s, done_s;
  assign tx_s   = sel ? tx2 : tx1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;

  // Pops are only legal in IDLE and never while reset is high.
  int rr_bad = 0;
  always @(negedge clk) begin
    if (rr1 && state1 != IDLE) rr_bad <= rr_bad + 1;
    else if (rr2 && state2 != IDLE) rr_bad <= rr_bad + 1;
    else if (reset && (rr1 || rr2)) rr_bad <= rr_bad + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic s, input logic [7:0] d);
    if (s) begin
      mem2[wr2] = d;
      wr2 = wr2 + 1;
    end else begin
      mem1[wr1] = d;
      wr1 = wr1 + 1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Waits for the start bit, then checks every cycle of the frame against a
  // bit list built from the hand-computed vector. exp_wait is the number of
  // tx-high busy samples seen before the start bit (the LOAD cycle).
  // Consumes one extra cycle after the frame to check busy has dropped.
  task automatic expect_frame(input logic s, input logic [7:0] data,
                              input logic pe, input logic exp_par,
                              input int exp_len, input int exp_wait,
                              input string tag);
    logic exp_bits [0:11];
    int nb, waited, bad_tx, bad_busy, done_at, bidx;
    logic started, prev_busy, save_en, save_odd, exp_tx;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
    nb = 9;
    if (pe) begin
      exp_bits[nb] = exp_par;
      nb = nb + 1;
    end
    exp_bits[nb] = 1'b1;
    nb = nb + 1;
    if (s) begin
      exp_bits[nb] = 1'b1;
      nb = nb + 1;
    end
    sel = s;
    started = 1'b0;
    waited = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 300 && !started; c++) begin
      @(negedge clk);
      if (tx_s == 1'b0) started = 1'b1;
      else begin
        waited++;
        prev_busy = busy_s;
      end
    end
    check({tag, "_start_seen"}, int'(started), 1);
    if (!started) return;
    check({tag, "_pre_start_gap"}, waited, exp_wait);
    check({tag, "_busy_in_load"}, int'(prev_busy), 1);
    // Mid-frame parity changes must not affect the frame.
    save_en = parity_en;
    save_odd = parity_odd;
    parity_en = ~parity_en;
    parity_odd = ~parity_odd;
    bad_tx = 0;
    bad_busy = 0;
    done_at = 0;
    for (int n = 1; n <= exp_len + 8 && done_at == 0; n++) begin
      if (n > 1) @(negedge clk);
      bidx = (n - 1) / CPB;
      exp_tx = (bidx < nb) ? exp_bits[bidx] : 1'b1;
      if (tx_s !== exp_tx) bad_tx++;
      if (busy_s !== 1'b1) bad_busy++;
      if (done_s === 1'b1) done_at = n;
    end
    check({tag, "_tx_bad_cycles"}, bad_tx, 0);
    check({tag, "_busy_low_cycles"}, bad_busy, 0);
    check({tag, "_done_cycle"}, done_at, exp_len);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy_s), 0);
    check({tag, "_done_after"}, int'(done_s), 0);
    parity_en = save_en;
    parity_odd = save_odd;
  endtask

  // ---------------- test ----------------
  vec_t vecs [0:8];

  initial begin
    int rd_snap, low_cnt, busy_cnt, rr_cnt;
    logic seen;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 40, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 44, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 44, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 44, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 40, 1'b0};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 44, 1'b1};
    vecs[7] = '{8'hA5, 1'b1, 1'b1, 1'b1, 48, 1'b1};
    vecs[8] = '{8'hFE, 1'b1, 1'b0, 1'b1, 48, 1'b1};

    // Reset state
    tick(3);
    check("rst_tx1", int'(tx1), 1);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_state1", int'(state1), int'(IDLE));
    check("rst_tx2", int'(tx2), 1);
    check("rst_busy2", int'(busy2), 0);

    // Byte pending while reset is held: no pop until release.
    push(1'b0, 8'h81);
    tick(2);
    check("rst_no_pop", rd1, 0);
    reset = 1'b0;
    expect_frame(1'b0, 8'h81, 1'b0, 1'b0, 40, 1, "rst_pending");

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      parity_en = vecs[v].par_en;
      parity_odd = vecs[v].par_odd;
      push(vecs[v].dut, vecs[v].data);
      expect_frame(vecs[v].dut, vecs[v].data, vecs[v].par_en, vecs[v].exp_par,
                   vecs[v].exp_len, 1, $sformatf("vec%0d", v));
    end

    // Back-to-back: IDLE sample already taken by busy_after, so one more
    // high (LOAD) sample precedes each following start bit.
    parity_en = 1'b0;
    parity_odd = 1'b0;
    rd_snap = rd1;
    push(1'b0, 8'h01);
    push(1'b0, 8'h02);
    push(1'b0, 8'h03);
    expect_frame(1'b0, 8'h01, 1'b0, 1'b0, 40, 1, "b2b0");
    expect_frame(1'b0, 8'h02, 1'b0, 1'b0, 40, 1, "b2b1");
    expect_frame(1'b0, 8'h03, 1'b0, 1'b0, 40, 1, "b2b2");
    check("b2b_pops", rd1 - rd_snap, 3);
    check("b2b_empty", int'(fifo_empty1), 1);

    // Long idle
    low_cnt = 0;
    busy_cnt = 0;
    rr_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) low_cnt++;
      if (busy1 !== 1'b0) busy_cnt++;
      if (rr1 !== 1'b0) rr_cnt++;
    end
    check("idle_tx_low", low_cnt, 0);
    check("idle_busy", busy_cnt, 0);
    check("idle_pops", rr_cnt, 0);
    push(1'b0, 8'hFF);
    expect_frame(1'b0, 8'hFF, 1'b0, 1'b0, 40, 1, "after_idle");

    // Reset during data bit 3 of 0x3C (frame cycles 17..20)
    push(1'b0, 8'h3C);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (tx1 == 1'b0) seen = 1'b1;
    end
    check("mid_rst_start_seen", int'(seen), 1);
    tick(17);
    check("mid_rst_bit3", int'(tx1), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", int'(tx1), 1);
    check("mid_rst_busy", int'(busy1), 0);
    check("mid_rst_done", int'(done1), 0);
    check("mid_rst_state", int'(state1), int'(IDLE));
    rd_snap = rd1;
    tick(2);
    reset = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) low_cnt++;
      if (busy1 !== 1'b0) busy_cnt++;
    end
    check("post_rst_tx_low", low_cnt, 0);
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_pops", rd1, rd_snap);

    check("pop_discipline", rr_bad, 0);
    check("pops_vs_pushes1", rd1, wr1);
    check("pops_vs_pushes2", rd2, wr2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmit engine that sits directly downstream of the TX sync_fifo. It pops bytes from the FIFO's read port and serialises each one onto the tx line as an 8N1-style frame. The frame has a start bit, LSB-first data, optional parity, and 1 or 2 stop bits. It has an internal baud counter and needs no external tick.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match FIFO DATA_WIDTH
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2 or more
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_read_req is high
fifo_read_req  output  1  single-cycle pop request to FIFO read_req
parity_en  input  1  1 = insert parity bit; sampled in LOAD
parity_odd  input  1  1 = odd parity, 0 = even parity; sampled in LOAD
tx  output  1  serial line; idle high
busy  output  1  high from LOAD through the last stop-bit cycle
tx_done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, baud_cnt=0, bit_idx=0.
- fifo_read_req is combinational: (state==IDLE) && !fifo_empty && !reset. It is never high outside IDLE.
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If !fifo_empty: assert fifo_read_req and go to LOAD next edge. Otherwise stay.
- LOAD (1 cycle):
  - Capture fifo_data into shift_reg.
  - Latch parity_en and parity_odd.
  - Compute parity_bit = ^data XOR parity_odd.
  - Clear baud_cnt; go to START.
  - tx stays 1 in this cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx=shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then shift right and increment bit_idx.
  - After bit DATA_WIDTH-1, go to PARITY if parity was latched enabled, else STOP.
- PARITY: tx=parity_bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle. Next state is IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT).
  - The bit boundary is baud_cnt==CLKS_PER_BIT-1, where the counter wraps to 0.
- Frame length (START through STOP) is exactly CLKS_PER_BIT*(1+DATA_WIDTH+P+STOP_BITS) cycles, where P is the latched parity_en.
- Back-to-back: if the FIFO is non-empty when IDLE is re-entered, the next start bit begins exactly 2 cycles after the last stop cycle (IDLE + LOAD, tx high). There is no extra idle time.
- Empty after a frame: the block stays in IDLE with tx=1 indefinitely. busy falls on the cycle after tx_done.
- Pop discipline:
  - Exactly one fifo_read_req per transmitted byte.
  - fifo_empty is ignored outside IDLE.
  - A FIFO write during a frame does not disturb the frame.
- Parity inputs changing mid-frame have no effect on the current frame.
- Reset mid-frame:
  - On the next edge tx=1, busy=0, tx_done=0, state=IDLE.
  - The partially sent byte is lost and not re-popped.
  - No fifo_read_req while reset is high.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, LOAD, START, DATA, PARITY, STOP}.
  - localparam UART_DATA_WIDTH=8.
  - localparam DEFAULT_CLKS_PER_BIT=868.
  - function parity_calc(data, odd).
- Sub-module: uart_baud_gen.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset, clear, en; output bit_tick.
  - The receiver reuses it later.

Test Plan:
- Single byte: CLKS_PER_BIT=4, parity off, push 0x55.
  - fifo_read_req pulses once. tx is high during LOAD.
  - Then tx = 0 (4 clk), then 1,0,1,0,1,0,1,0 (4 clk each), then 1 (4 clk).
  - tx_done pulses at frame cycle 40. busy lasts 41 cycles.
- Parity: push 0xA5 (four 1s) with parity_en=1.
  - parity_odd=0: parity bit=0.
  - parity_odd=1: parity bit=1.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: preload FIFO with 0x01, 0x02, 0x03.
  - Three frames are sent in order with exactly 2 high cycles between stop end and next start.
  - Three read_req pulses total. fifo_empty is high after the third pop.
- Empty/idle: no writes for 1000 cycles.
  - tx=1, busy=0, fifo_read_req never asserted.
  - Push 0xFF: frame starts exactly 2 cycles after fifo_empty deasserts.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C.
  - Next edge gives tx=1, busy=0.
  - After release with an empty FIFO, no frame is sent and no extra pop occurs.
- STOP_BITS=2 with CLKS_PER_BIT=4: stop high lasts 8 cycles. tx_done is on the last of them.
